// File: rtl/ping_sequencer_if.sv
// ping_sequencer_if: host-side control/status bundle between the register block and the ping sequencer
interface ping_sequencer_if #(parameter int CNT_W = 16);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] damp_len;
  logic [CNT_W-1:0] listen_len;
  logic [1:0]       state;
  logic             busy;
  logic             listen;
  logic             done;
  logic             err;
  modport master (output start, abort, burst_len, damp_len, listen_len,
                  input  state, busy, listen, done, err);
  modport slave  (input  start, abort, burst_len, damp_len, listen_len,
                  output state, busy, listen, done, err);
endinterface

// File: rtl/ping_sequencer.sv
// ping_sequencer: drives the H-bridge mode through guard, burst, damp and listen phases for one ping
module ping_sequencer #(
  parameter int CNT_W = 16,
  parameter int GUARD = 8
) (
  input logic            clk,
  input logic            rst,
  ping_sequencer_if.slave bus
);
  localparam logic [1:0] M_HIGHZ = 2'b00;
  localparam logic [1:0] M_DAMP  = 2'b01;
  localparam logic [1:0] M_OSCL  = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_GUARD, S_BURST, S_DAMP, S_LISTEN} fsm_t;
  fsm_t             fsm, fsm_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] bl, bl_n, dl, dl_n, ll, ll_n;
  logic             abt, abt_n;
  logic             err_n;
  logic [1:0]       state_n;
  logic [1:0]       state_q;
  logic             busy_q, listen_q, done_q, err_q;
  // Phase sequencing; abort takes priority over the normal phase exit, and an
  // abort from OSCL always passes through DAMP so the bridge is damped first.
  always_comb begin
    fsm_n = fsm;
    cnt_n = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    bl_n  = bl;
    dl_n  = dl;
    ll_n  = ll;
    abt_n = abt;
    err_n = 1'b0;
    case (fsm)
      S_IDLE:
        if (!bus.abort && bus.start) begin
          if (bus.burst_len != '0) begin
            fsm_n = S_GUARD;
            cnt_n = CNT_W'(GUARD - 1);
            bl_n  = bus.burst_len;
            dl_n  = bus.damp_len;
            ll_n  = bus.listen_len;
            abt_n = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
      S_GUARD:
        if (bus.abort) begin
          fsm_n = S_IDLE;
        end else if (cnt == '0) begin
          fsm_n = S_BURST;
          cnt_n = bl - CNT_W'(1);
        end
      S_BURST:
        if (bus.abort) begin
          fsm_n = S_DAMP;
          cnt_n = (dl != '0) ? dl - CNT_W'(1) : '0;
          abt_n = 1'b1;
        end else if (cnt == '0) begin
          fsm_n = (dl != '0) ? S_DAMP : (ll != '0) ? S_LISTEN : S_IDLE;
          cnt_n = (dl != '0) ? dl - CNT_W'(1) : (ll != '0) ? ll - CNT_W'(1) : '0;
        end
      S_DAMP: begin
        abt_n = abt | bus.abort;
        if (cnt == '0) begin
          fsm_n = (abt || bus.abort || ll == '0) ? S_IDLE : S_LISTEN;
          cnt_n = (abt || bus.abort || ll == '0) ? '0 : ll - CNT_W'(1);
        end
      end
      S_LISTEN:
        if (bus.abort || cnt == '0) fsm_n = S_IDLE;
      default: fsm_n = S_IDLE;
    endcase
    state_n = (fsm_n == S_BURST) ? M_OSCL : (fsm_n == S_DAMP) ? M_DAMP : M_HIGHZ;
  end
  // State, counter, latched config and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= S_IDLE;
      cnt      <= '0;
      bl       <= '0;
      dl       <= '0;
      ll       <= '0;
      abt      <= 1'b0;
      state_q  <= M_HIGHZ;
      busy_q   <= 1'b0;
      listen_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      fsm      <= fsm_n;
      cnt      <= cnt_n;
      bl       <= bl_n;
      dl       <= dl_n;
      ll       <= ll_n;
      abt      <= abt_n;
      state_q  <= state_n;
      busy_q   <= fsm_n != S_IDLE;
      listen_q <= fsm_n == S_LISTEN;
      done_q   <= fsm != S_IDLE && fsm_n == S_IDLE;
      err_q    <= err_n;
    end
  end
  assign bus.state  = state_q;
  assign bus.busy   = busy_q;
  assign bus.listen = listen_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_ping_sequencer.sv
// tb_ping_sequencer: directed pings with an event scoreboard checking phase lengths on every done/err
module tb_ping_sequencer;
  typedef struct {int e; int g; int o; int d; int l;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  ping_sequencer_if #(.CNT_W(16)) bus();
  ping_sequencer #(.CNT_W(16), .GUARD(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask
  // Monitor: counts phase cycles while busy, compares against the queued expectation on done/err
  initial begin
    int g = 0, o = 0, d = 0, l = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        g = 0; o = 0; d = 0; l = 0;
      end else begin
        if (bus.busy) begin
          if (bus.listen) l++;
          else if (bus.state == 2'b10) o++;
          else if (bus.state == 2'b01) d++;
          else g++;
        end
        if (bus.done || bus.err) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: done=%0b err=%0b with empty scoreboard", bus.done, bus.err);
          end else begin
            e = q.pop_front();
            chk("err", int'(bus.err), e.e);
            chk("done", int'(bus.done), 1 - e.e);
            chk("busy_at_event", int'(bus.busy), 0);
            chk("guard_cycles", g, e.g);
            chk("oscl_cycles", o, e.o);
            chk("damp_cycles", d, e.d);
            chk("listen_cycles", l, e.l);
          end
          g = 0; o = 0; d = 0; l = 0;
        end
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go(input int b, input int d, input int l);
    bus.burst_len  = 16'(b);
    bus.damp_len   = 16'(d);
    bus.listen_len = 16'(l);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic issue(input int b, input int d, input int l,
                       input int ee, input int eg, input int eo, input int ed, input int el);
    exp_t x;
    x.e = ee; x.g = eg; x.o = eo; x.d = ed; x.l = el;
    q.push_back(x);
    go(b, d, l);
  endtask
  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 300) begin
      step();
      k++;
    end
    if (bus.busy) tmo("wait_idle");
    step(2);
  endtask
  task automatic wait_mode(input logic [1:0] m);
    int k = 0;
    while (bus.state != m && k < 100) begin
      step();
      k++;
    end
    if (bus.state != m) tmo("wait_mode");
  endtask
  task automatic wait_listen();
    int k = 0;
    while (!bus.listen && k < 100) begin
      step();
      k++;
    end
    if (!bus.listen) tmo("wait_listen");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.burst_len = '0;
    bus.damp_len = '0;
    bus.listen_len = '0;
    #2;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_listen", int'(bus.listen), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    step(3);
    rst = 1'b1;
    step(2);
    issue(4, 3, 5, 0, 8, 4, 3, 5);
    wait_idle();
    issue(2, 0, 0, 0, 8, 2, 0, 0);
    wait_idle();
    issue(4, 0, 5, 0, 8, 4, 0, 5);
    wait_idle();
    issue(4, 3, 0, 0, 8, 4, 3, 0);
    wait_idle();
    issue(1, 1, 1, 0, 8, 1, 1, 1);
    wait_idle();
    issue(0, 3, 5, 1, 0, 0, 0, 0);
    step(2);
    chk("reject_busy", int'(bus.busy), 0);
    issue(4, 3, 5, 0, 8, 4, 3, 5);
    step(3);
    bus.burst_len = 16'd0;
    bus.damp_len = 16'd9;
    bus.listen_len = 16'd1;
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    wait_idle();
    issue(4, 3, 5, 0, 8, 2, 3, 0);
    wait_mode(2'b10);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_idle();
    issue(4, 0, 5, 0, 8, 2, 1, 0);
    wait_mode(2'b10);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_idle();
    issue(4, 3, 5, 0, 3, 0, 0, 0);
    step(2);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_idle();
    issue(4, 3, 5, 0, 8, 4, 3, 2);
    wait_listen();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_idle();
    issue(4, 3, 5, 0, 8, 4, 3, 0);
    wait_mode(2'b01);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    wait_idle();
    bus.abort = 1'b1;
    go(4, 3, 5);
    bus.abort = 1'b0;
    step(2);
    chk("start_abort_busy", int'(bus.busy), 0);
    go(4, 3, 5);
    wait_mode(2'b10);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.state), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    step(2);
    chk("async_rst_done", int'(bus.done), 0);
    rst = 1'b1;
    step(3);
    chk("post_rst_busy", int'(bus.busy), 0);
    issue(3, 2, 2, 0, 8, 3, 2, 2);
    wait_idle();
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
